// File: rtl/iic_pkg.sv
// Shared IIC byte-level command encodings, used by the IIC master and its clients.
package iic_pkg;

    // One-hot byte-level commands issued to the IIC master.
    typedef enum logic [5:0] {
        IIC_IDLE      = 6'b000000,
        IIC_START     = 6'b000001,
        IIC_WRITE     = 6'b000010,
        IIC_READ      = 6'b000100,
        IIC_READ_LAST = 6'b001000,
        IIC_STOP      = 6'b010000
    } iic_cmd_t;

    localparam int unsigned IIC_CMD_W = 6;

endpackage

// File: rtl/eeprom_ctrl_if.sv
// Request/response and IIC-master signal bundle for the EEPROM controller.
import iic_pkg::*;

interface eeprom_ctrl_if;

    // client request / response
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    // IIC master byte-level side
    iic_cmd_t   iic_cmd;
    logic [7:0] iic_tx_data;
    logic [7:0] iic_rx_data;
    logic       iic_done;
    logic [1:0] iic_status;

    // environment side: issues requests, hosts the IIC master
    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  iic_cmd, iic_tx_data,
        output iic_rx_data, iic_done, iic_status
    );

    // controller side
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output iic_cmd, iic_tx_data,
        input  iic_rx_data, iic_done, iic_status
    );

endinterface

// File: rtl/eeprom_ctrl.sv
// EEPROM byte write / random byte read sequencer on top of a byte-level IIC master.
import iic_pkg::*;

module eeprom_ctrl #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter logic [15:0] TWR_CYCLES = 16'd50000
) (
    input logic          sys_clk,
    input logic          sys_rst,
    eeprom_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_WADDR, S_WDATA,
        S_RSTART, S_DEVR, S_RDATA, S_STOP, S_TWAIT, S_RESP
    } state_t;

    state_t     state, state_nxt;
    logic       issued, issued_nxt;
    logic       is_cmd_state, issue;
    iic_cmd_t   cmd_sel;
    logic [7:0] data_sel;
    logic       accept, done_ok, nack, twait_end, wr_state;

    iic_cmd_t   cmd_q;
    logic [7:0] tx_q, rdata_q;
    logic       rw_q, err_q;
    logic [7:0] addr_q, wdata_q;
    logic [15:0] cnt_q;

    // The done pulse is the only handshake used; the busy bit is informational.
    logic       busy_unused;
    assign busy_unused = bus.iic_status[0];

    assign accept    = bus.req_valid && (state == S_IDLE);
    assign done_ok   = issued && bus.iic_done;
    assign nack      = bus.iic_status[1];
    assign twait_end = ({1'b0, cnt_q} + 17'd1) >= {1'b0, TWR_CYCLES};
    assign wr_state  = (state == S_DEVW) || (state == S_WADDR) ||
                       (state == S_WDATA) || (state == S_DEVR);

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_err     = (state == S_RESP) && err_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.iic_cmd     = cmd_q;
    assign bus.iic_tx_data = tx_q;

    // State register and per-state "command already issued" flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= S_IDLE;
            issued <= 1'b0;
        end else begin
            state  <= state_nxt;
            issued <= issued_nxt;
        end
    end

    // Next-state decode plus the command/byte each command state issues.
    always_comb begin
        state_nxt    = state;
        cmd_sel      = IIC_IDLE;
        data_sel     = '0;
        is_cmd_state = 1'b1;
        unique case (state)
            S_IDLE: begin
                is_cmd_state = 1'b0;
                if (accept) state_nxt = S_START;
            end
            S_START: begin
                cmd_sel = IIC_START;
                if (done_ok) state_nxt = S_DEVW;
            end
            S_DEVW: begin
                cmd_sel  = IIC_WRITE;
                data_sel = {DEV_ADDR, 1'b0};
                if (done_ok) state_nxt = nack ? S_STOP : S_WADDR;
            end
            S_WADDR: begin
                cmd_sel  = IIC_WRITE;
                data_sel = addr_q;
                if (done_ok) state_nxt = nack ? S_STOP : (rw_q ? S_RSTART : S_WDATA);
            end
            S_WDATA: begin
                cmd_sel  = IIC_WRITE;
                data_sel = wdata_q;
                if (done_ok) state_nxt = S_STOP;
            end
            S_RSTART: begin
                cmd_sel = IIC_START;
                if (done_ok) state_nxt = S_DEVR;
            end
            S_DEVR: begin
                cmd_sel  = IIC_WRITE;
                data_sel = {DEV_ADDR, 1'b1};
                if (done_ok) state_nxt = nack ? S_STOP : S_RDATA;
            end
            S_RDATA: begin
                cmd_sel = IIC_READ_LAST;
                if (done_ok) state_nxt = S_STOP;
            end
            S_STOP: begin
                cmd_sel = IIC_STOP;
                // errored or read transactions never started an internal write cycle
                if (done_ok) state_nxt = (err_q || rw_q) ? S_RESP : S_TWAIT;
            end
            S_TWAIT: begin
                is_cmd_state = 1'b0;
                if (twait_end) state_nxt = S_RESP;
            end
            S_RESP: begin
                is_cmd_state = 1'b0;
                state_nxt    = S_IDLE;
            end
            default: begin
                is_cmd_state = 1'b0;
                state_nxt    = S_IDLE;
            end
        endcase
        issue      = is_cmd_state && !issued;
        issued_nxt = (state_nxt != state) ? 1'b0 : (issued || issue);
    end

    // Registered command outputs, request capture, error flag, read data and write-cycle timer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cmd_q   <= IIC_IDLE;
            tx_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cmd_q <= issue ? cmd_sel : IIC_IDLE;
            if (issue) tx_q <= data_sel;
            if (accept) begin
                rw_q    <= bus.req_rw;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == S_RESP)
                err_q <= 1'b0;
            else if (done_ok && wr_state && nack)
                err_q <= 1'b1;
            if (done_ok && state == S_RDATA) rdata_q <= bus.iic_rx_data;
            cnt_q <= (state == S_TWAIT) ? cnt_q + 16'd1 : '0;
        end
    end

endmodule
